// File: rtl/irq_pkg.sv
// Shared definitions for the user-mode interrupt controller: register map,
// cause codes, PENDING/ENABLE bit positions and the FSM state type.
package irq_pkg;

    localparam logic [2:0] REG_PENDING  = 3'd0;
    localparam logic [2:0] REG_ENABLE   = 3'd1;
    localparam logic [2:0] REG_SWI      = 3'd2;
    localparam logic [2:0] REG_MTIME    = 3'd3;
    localparam logic [2:0] REG_MTIMECMP = 3'd4;
    localparam logic [2:0] REG_STATUS   = 3'd5;

    localparam logic [4:0] CAUSE_SW       = 5'd0;
    localparam logic [4:0] CAUSE_TIM      = 5'd4;
    localparam logic [4:0] CAUSE_EXT_BASE = 5'd8;

    localparam int EXT_LSB = 8;
    localparam int TIM_BIT = 4;
    localparam int SW_BIT  = 0;

    typedef enum logic {
        IDLE    = 1'b0,
        SERVICE = 1'b1
    } state_e;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser for one asynchronous interrupt line, followed by a
// rising-edge detector; rise is high for one cycle per 0->1 transition.
module irq_sync_edge (
    input  logic clk,
    input  logic rstn,
    input  logic irq_async,
    output logic rise
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = irq_async;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/irq_ctrl.sv
// User-mode interrupt controller: pending/enable latching, fixed priority,
// free-running timer with compare, MMIO registers and the take/uret FSM.
//   state   | meaning
//   IDLE    | no handler active; an eligible candidate is taken at retire
//   SERVICE | handler running; requests masked until uret
module irq_ctrl #(
    parameter int NSRC = 4,
    parameter int TW   = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [NSRC-1:0] ext_irq,
    input  logic            reg_we,
    input  logic [2:0]      reg_addr,
    input  logic [31:0]     reg_wdata,
    output logic [31:0]     reg_rdata,
    input  logic            uie,
    input  logic            retire,
    input  logic            exception,
    input  logic            uret,
    output logic            interrupt,
    output logic [31:0]     icause,
    output logic            busy
);
    import irq_pkg::*;

    logic [NSRC-1:0] ext_rise;
    logic [NSRC-1:0] pend_ext_q, pend_ext_d, en_ext_q, en_ext_d;
    logic            pend_sw_q, pend_sw_d, en_tim_q, en_tim_d, en_sw_q, en_sw_d;
    logic [TW-1:0]   mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
    state_e          state_q, state_d;

    logic            pend_tim, any_cand;
    logic [NSRC-1:0] cand_ext, claim_oh;
    logic [4:0]      code;
    logic [31:0]     pend_vec, en_vec;

    for (genvar i = 0; i < NSRC; i++) begin : g_sync
        irq_sync_edge u_sync (
            .clk       (clk),
            .rstn      (rstn),
            .irq_async (ext_irq[i]),
            .rise      (ext_rise[i])
        );
    end

    always_comb begin
        pend_tim = (mtime_q >= mtimecmp_q);
        cand_ext = pend_ext_q & en_ext_q;
        any_cand = 1'b0;
        code     = CAUSE_SW;
        claim_oh = '0;
        if (pend_sw_q && en_sw_q) begin
            any_cand = 1'b1;
            code     = CAUSE_SW;
        end
        if (pend_tim && en_tim_q) begin
            any_cand = 1'b1;
            code     = CAUSE_TIM;
        end
        // Walk from the highest index down so the lowest ext line wins.
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (cand_ext[i]) begin
                any_cand    = 1'b1;
                code        = CAUSE_EXT_BASE + 5'(i);
                claim_oh    = '0;
                claim_oh[i] = 1'b1;
            end
        end
    end

    assign icause    = any_cand ? {1'b1, 26'b0, code} : 32'b0;
    assign interrupt = (state_q == IDLE) & any_cand & uie & retire & ~exception;
    assign busy      = (state_q == SERVICE);

    always_comb begin
        pend_vec                  = '0;
        pend_vec[EXT_LSB +: NSRC] = pend_ext_q;
        pend_vec[TIM_BIT]         = pend_tim;
        pend_vec[SW_BIT]          = pend_sw_q;
        en_vec                    = '0;
        en_vec[EXT_LSB +: NSRC]   = en_ext_q;
        en_vec[TIM_BIT]           = en_tim_q;
        en_vec[SW_BIT]            = en_sw_q;
        case (reg_addr)
            REG_PENDING:  reg_rdata = pend_vec;
            REG_ENABLE:   reg_rdata = en_vec;
            REG_SWI:      reg_rdata = {31'b0, pend_sw_q};
            REG_MTIME:    reg_rdata = mtime_q;
            REG_MTIMECMP: reg_rdata = mtimecmp_q;
            REG_STATUS:   reg_rdata = {31'b0, busy};
            default:      reg_rdata = 32'b0;
        endcase
    end

    always_comb begin
        pend_ext_d = pend_ext_q;
        pend_sw_d  = pend_sw_q;
        en_ext_d   = en_ext_q;
        en_tim_d   = en_tim_q;
        en_sw_d    = en_sw_q;
        mtime_d    = mtime_q + TW'(1);
        mtimecmp_d = mtimecmp_q;
        state_d    = state_q;
        if (reg_we) begin
            case (reg_addr)
                REG_PENDING:  pend_ext_d = pend_ext_d & ~reg_wdata[EXT_LSB +: NSRC];
                REG_ENABLE: begin
                    en_ext_d = reg_wdata[EXT_LSB +: NSRC];
                    en_tim_d = reg_wdata[TIM_BIT];
                    en_sw_d  = reg_wdata[SW_BIT];
                end
                REG_SWI:      pend_sw_d  = reg_wdata[0];
                REG_MTIME:    mtime_d    = reg_wdata[TW-1:0];
                REG_MTIMECMP: mtimecmp_d = reg_wdata[TW-1:0];
                default:      ;
            endcase
        end
        if (interrupt) begin
            pend_ext_d = pend_ext_d & ~claim_oh;
            state_d    = SERVICE;
        end else if (state_q == SERVICE && uret) begin
            state_d = IDLE;
        end
        // New edges are applied last so they survive a same-cycle clear or claim.
        pend_ext_d = pend_ext_d | ext_rise;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_ext_q <= '0;
            pend_sw_q  <= 1'b0;
            en_ext_q   <= '0;
            en_tim_q   <= 1'b0;
            en_sw_q    <= 1'b0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            state_q    <= IDLE;
        end else begin
            pend_ext_q <= pend_ext_d;
            pend_sw_q  <= pend_sw_d;
            en_ext_q   <= en_ext_d;
            en_tim_q   <= en_tim_d;
            en_sw_q    <= en_sw_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            state_q    <= state_d;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: expectations are queued as stimulus is driven
// and popped against DUT outputs sampled 1 time unit after the clock edge.
module tb_irq_ctrl;
    import irq_pkg::*;

    localparam int NSRC = 4;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [NSRC-1:0] ext_irq = '0;
    logic            reg_we = 1'b0;
    logic [2:0]      reg_addr = 3'd0;
    logic [31:0]     reg_wdata = 32'd0;
    logic [31:0]     reg_rdata;
    logic            uie = 1'b0, retire = 1'b0, exception = 1'b0, uret = 1'b0;
    logic            interrupt;
    logic [31:0]     icause;
    logic            busy;

    always #5 clk = ~clk;

    irq_ctrl #(.NSRC(NSRC), .TW(32)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .ext_irq   (ext_irq),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .uie       (uie),
        .retire    (retire),
        .exception (exception),
        .uret      (uret),
        .interrupt (interrupt),
        .icause    (icause),
        .busy      (busy)
    );

    int          total = 0;
    int          bad = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    task automatic push(input string t, input logic [31:0] e);
        tag_q.push_back(t);
        exp_q.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%h", obs);
            return;
        end
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", t, obs, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        reg_we    = 1'b1;
        reg_addr  = a;
        reg_wdata = d;
        tick();
        reg_we    = 1'b0;
    endtask

    task automatic chk_rd(input string t, input logic [2:0] a, input logic [31:0] e);
        push(t, e);
        reg_addr = a;
        #1;
        pop_chk(reg_rdata);
    endtask

    task automatic chk_out(input string t, input logic i, input logic [31:0] c, input logic b);
        push({t, "_irq"}, {31'b0, i});
        push({t, "_cause"}, c);
        push({t, "_busy"}, {31'b0, b});
        #1;
        pop_chk({31'b0, interrupt});
        pop_chk(icause);
        pop_chk({31'b0, busy});
    endtask

    task automatic pulse_ext(input int i);
        ext_irq[i] = 1'b1;
        tick();
        ext_irq[i] = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_uret();
        uret = 1'b1;
        tick();
        uret = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #12;
        chk_out("rst", 1'b0, 32'h0, 1'b0);
        chk_rd("rst_cmp", REG_MTIMECMP, 32'hFFFF_FFFF);
        chk_rd("rst_pend", REG_PENDING, 32'h0);
        rstn = 1'b1;
        tick();

        // Enable ext[0]; the pending bit appears on the 3rd edge
        wr(REG_ENABLE, 32'h100);
        ext_irq[0] = 1'b1;
        push("sync_e1", 32'h0);
        push("sync_e2", 32'h0);
        push("sync_e3", 32'h100);
        for (int k = 0; k < 3; k++) begin
            tick();
            reg_addr = REG_PENDING;
            #1;
            pop_chk(reg_rdata);
        end
        uie = 1'b1;
        retire = 1'b1;
        chk_out("take0", 1'b1, 32'h8000_0008, 1'b0);
        tick();
        retire = 1'b0;
        chk_out("svc0", 1'b0, 32'h0, 1'b1);
        chk_rd("claim0", REG_PENDING, 32'h0);
        chk_rd("status0", REG_STATUS, 32'h1);
        tick();
        tick();
        chk_rd("level_ignored", REG_PENDING, 32'h0);
        ext_irq[0] = 1'b0;
        tick();
        tick();

        // New edge while in SERVICE: latched but not taken
        retire = 1'b1;
        pulse_ext(0);
        chk_out("svc_hold", 1'b0, 32'h8000_0008, 1'b1);
        chk_rd("svc_pend", REG_PENDING, 32'h100);
        uret = 1'b1;
        chk_out("uret_cyc", 1'b0, 32'h8000_0008, 1'b1);
        tick();
        uret = 1'b0;
        chk_out("retake", 1'b1, 32'h8000_0008, 1'b0);
        tick();
        retire = 1'b0;
        do_uret();
        chk_out("idle1", 1'b0, 32'h0, 1'b0);

        // W1C racing a new edge on the same bit
        uie = 1'b0;
        pulse_ext(0);
        chk_rd("race_pre", REG_PENDING, 32'h100);
        tick();
        tick();
        ext_irq[0] = 1'b1;
        tick();
        ext_irq[0] = 1'b0;
        tick();
        wr(REG_PENDING, 32'h100);
        chk_rd("race_setwins", REG_PENDING, 32'h100);
        wr(REG_PENDING, 32'h100);
        chk_rd("w1c", REG_PENDING, 32'h0);

        // Priority ext0 > ext2 > timer
        wr(REG_ENABLE, 32'h510);
        wr(REG_MTIMECMP, 32'h0);
        pulse_ext(2);
        pulse_ext(0);
        chk_rd("prio_pend", REG_PENDING, 32'h510);
        uie = 1'b1;
        retire = 1'b1;
        chk_out("prio1", 1'b1, 32'h8000_0008, 1'b0);
        tick();
        retire = 1'b0;
        chk_out("prio1_svc", 1'b0, 32'h8000_000A, 1'b1);
        do_uret();
        retire = 1'b1;
        chk_out("prio2", 1'b1, 32'h8000_000A, 1'b0);
        tick();
        retire = 1'b0;
        do_uret();
        retire = 1'b1;
        chk_out("prio3", 1'b1, 32'h8000_0004, 1'b0);
        tick();
        retire = 1'b0;
        do_uret();
        wr(REG_MTIMECMP, 32'hFFFF_FFFF);
        wr(REG_ENABLE, 32'h0);
        chk_rd("prio_clear", REG_PENDING, 32'h0);

        // Masking by uie and exception
        wr(REG_ENABLE, 32'h1);
        wr(REG_SWI, 32'h1);
        chk_rd("swi_rd", REG_SWI, 32'h1);
        uie = 1'b0;
        retire = 1'b1;
        chk_out("mask_uie", 1'b0, 32'h8000_0000, 1'b0);
        tick();
        uie = 1'b1;
        exception = 1'b1;
        chk_out("mask_exc", 1'b0, 32'h8000_0000, 1'b0);
        tick();
        exception = 1'b0;
        chk_out("exc_idle", 1'b1, 32'h8000_0000, 1'b0);
        tick();
        retire = 1'b0;
        chk_out("sw_svc", 1'b0, 32'h8000_0000, 1'b1);
        do_uret();
        wr(REG_SWI, 32'h0);
        chk_rd("sw_clear", REG_PENDING, 32'h0);

        // Timer wrap with unsigned compare
        wr(REG_ENABLE, 32'h10);
        wr(REG_MTIMECMP, 32'h2);
        wr(REG_MTIME, 32'hFFFF_FFFE);
        chk_rd("mt_fffe", REG_MTIME, 32'hFFFF_FFFE);
        chk_rd("tim_fffe", REG_PENDING, 32'h10);
        tick();
        chk_rd("tim_ffff", REG_PENDING, 32'h10);
        tick();
        chk_rd("mt_wrap", REG_MTIME, 32'h0);
        chk_rd("tim_0", REG_PENDING, 32'h0);
        tick();
        chk_rd("tim_1", REG_PENDING, 32'h0);
        chk_out("tim_1_out", 1'b0, 32'h0, 1'b0);
        tick();
        chk_rd("tim_2", REG_PENDING, 32'h10);
        retire = 1'b1;
        chk_out("tim_take", 1'b1, 32'h8000_0004, 1'b0);
        tick();
        retire = 1'b0;
        do_uret();
        wr(REG_MTIMECMP, 32'hFFFF_FFFF);
        wr(REG_ENABLE, 32'h0);
        chk_rd("bad_addr", 3'd6, 32'h0);

        // Reset asserted mid-SERVICE
        wr(REG_ENABLE, 32'h1);
        wr(REG_SWI, 32'h1);
        retire = 1'b1;
        tick();
        retire = 1'b0;
        chk_out("pre_rst", 1'b0, 32'h8000_0000, 1'b1);
        rstn = 1'b0;
        chk_out("async_rst", 1'b0, 32'h0, 1'b0);
        chk_rd("rst_pend2", REG_PENDING, 32'h0);
        chk_rd("rst_en2", REG_ENABLE, 32'h0);
        chk_rd("rst_cmp2", REG_MTIMECMP, 32'hFFFF_FFFF);
        tick();
        rstn = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
User-mode interrupt controller that sits directly upstream of the CSR file. It collects software, timer and external interrupt sources, latches them as pending, and prioritises them. At an instruction boundary it drives the CSR file's interrupt/icause inputs. It then masks further requests until the handler executes uret. It also owns a free-running timer with a compare register, and exposes memory-mapped control registers to the load/store path.

Parameters:
NSRC, 4, number of external interrupt lines (1..8).
TW, 32, width of the mtime/mtimecmp timer registers (fixed 32 in this revision).

Ports:
clk  input  1  system clock.
rstn  input  1  reset, asynchronous assert, active-low.
ext_irq  input  NSRC  asynchronous external lines; rising edge requests.
reg_we  input  1  MMIO write strobe.
reg_addr  input  3  MMIO word index.
reg_wdata  input  32  MMIO write data.
reg_rdata  output  32  MMIO read data (combinational from addr).
uie  input  1  ustatus.UIE from the CSR file.
retire  input  1  an instruction completes this cycle (boundary).
exception  input  1  synchronous exception this cycle.
uret  input  1  uret executes this cycle.
interrupt  output  1  take interrupt now; feeds CSR interrupt.
icause  output  32  cause for CSR icause.
busy  output  1  handler in service (state SERVICE).

Behaviour:
- Reset (rstn=0, async): pending=0, enable=0, mtime=0, mtimecmp=32'hFFFF_FFFF, sync flops=0, state=IDLE; interrupt=0, icause=0, busy=0, reg_rdata reflects reset values.
- External path: each ext_irq[i] has a 2-flop synchroniser plus an edge register. pend_ext[i] sets on the 3rd rising clk edge after the line rises. Levels are ignored; only a 0->1 edge sets the bit.
- Timer: mtime += 1 every cycle and wraps FFFF_FFFF->0. pend_tim = (mtime >= mtimecmp), unsigned, level-sensitive, recomputed each cycle from registers. It is not latched.
- Software: a write to SWI with wdata[0]=1 sets pend_sw. A write with wdata[0]=0 clears it.
- Register map (reg_addr):
  - 0 PENDING: {.., ext[NSRC-1:0] at [8+:NSRC], tim at [4], sw at [0]}. Write-1-to-clear on the ext bits only.
  - 1 ENABLE: same bit layout, read/write.
  - 2 SWI.
  - 3 MTIME, R/W.
  - 4 MTIMECMP, R/W.
  - 5 STATUS: {31'b0, busy}, read-only.
  - Other addresses: read 0, writes ignored.
- Candidate = pending & enable. Priority is fixed: ext[0] > ext[1] > ... > timer > software.
- icause = {1'b1, 26'b0, code5}, with codes sw=0, timer=4, ext[i]=8+i. It is driven from the current highest candidate and is 0 when there is no candidate.
- FSM has two states, IDLE and SERVICE.
  - IDLE: interrupt = any_candidate & uie & retire & ~exception. This is combinational from registered state, so the CSR latches pc4 the same cycle.
  - On that cycle: the chosen ext bit is cleared (auto-claim) and the next state is SERVICE. sw and timer are not auto-cleared; software clears them via SWI / MTIMECMP.
  - SERVICE: interrupt=0. uret moves the FSM to IDLE on the next edge. The earliest re-take is the cycle after uret.
- Simultaneous events:
  - exception with retire: no interrupt (exception wins); the FSM stays in IDLE.
  - ext edge set and W1C clear on the same bit in the same cycle: set wins.
  - claim and new edge on the same bit: set wins, so the bit stays pending.
  - MMIO write to MTIME and the increment in the same cycle: the write wins.
  - uret in IDLE: ignored.
- Reset mid-SERVICE returns to IDLE with all state cleared. Synchroniser contents are discarded.

Decomposition:
- Shared package irq_pkg holds:
  - register index constants: REG_PENDING..REG_STATUS;
  - cause codes: CAUSE_SW=0, CAUSE_TIM=4, CAUSE_EXT_BASE=8;
  - the state enum {IDLE, SERVICE}.
- One sub-module, irq_sync_edge: a per-line 2-flop synchroniser plus rising-edge detector, instantiated NSRC times.

Test Plan:
- Reset and enable:
  - Reset -> MTIMECMP reads FFFF_FFFF, PENDING reads 0, interrupt=0.
  - Write ENABLE=0x100, pulse ext_irq[0] -> PENDING bit8 set 3 edges later.
  - uie=1, retire=1 -> interrupt=1, icause=8000_0008, busy=1 next cycle, PENDING bit8=0.
- Priority: enable ext[0], ext[2], timer; set ext[2] and timer pending, then ext[0] -> icause 8000_0008 is taken first. After uret, icause 8000_000A is taken next; timer is taken last.
- Masking and exception:
  - Candidate pending with uie=0 -> no interrupt.
  - uie=1, retire=1, exception=1 -> no interrupt, state IDLE.
  - Next retire without exception -> interrupt is taken.
- Timer wrap: MTIME=FFFF_FFFE, MTIMECMP=2, timer enabled -> no request while mtime wraps to 0,1. At mtime=2 the request fires with icause=8000_0004.
- SERVICE hold: in SERVICE, assert a new ext edge -> no interrupt and pending stays set. uret -> interrupt on the first eligible retire after uret.
- Races:
  - W1C to bit8 in the same cycle as a new ext[0] edge -> bit8 remains 1.
  - Assert rstn=0 while busy=1 -> busy=0 and PENDING=0 immediately (asynchronous).
